axi_lite_ram: RTL and testbench

AXI4-lite subordinate memory that answers the CPU core's AXI4-lite initiator port, for both instruction fetch and data load/store. It holds a word-organised RAM behind independent read and write channel state machines. It applies per-byte write strobes and returns OKAY, SLVERR or DECERR responses. It sits between the core's memory interface and the top level, as the single memory of the test SoC.

---
 rtl/axi_lite_ram_if.sv | 38 +++
 rtl/axi_lite_ram.sv | 232 +++++++++++++++++++++++
 tb/tb_axi_lite_ram.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_ram_if.sv
// AXI4-lite bundle between the core's initiator port and the test SoC memory.
interface axi_lite_ram_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddress;
  logic [2:0]        awprot;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddress;
  logic [2:0]        arprot;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output awvalid, awaddress, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddress, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddress, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddress, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_ram.sv
// AXI4-lite word RAM with independent read/write channel FSMs, byte strobes,
// write-protected instruction space and DECERR outside the mapped window.
module axi_lite_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_WAIT   = 0
) (
  input logic           clk,
  input logic           reset,
  axi_lite_ram_if.slave bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SPAN_W = ADDR_W + 1;
  localparam logic [SPAN_W-1:0] SPAN = SPAN_W'(DEPTH_WORDS) << 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_FETCH, R_RESP} rstate_t;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Write channel registers
  wstate_t           w_state, w_state_d;
  logic              aw_held, aw_held_d;
  logic              w_held, w_held_d;
  logic [ADDR_W-1:0] aw_addr, aw_addr_d;
  logic              aw_instr, aw_instr_d;
  logic [DATA_W-1:0] w_data, w_data_d;
  logic [STRB_W-1:0] w_strb, w_strb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              ram_we;

  // Read channel registers
  rstate_t           r_state, r_state_d;
  logic [ADDR_W-1:0] ar_addr, ar_addr_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [ADDR_W-1:0] aw_off, ar_off;
  logic              aw_in_range, ar_in_range;
  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic              aw_hs, w_hs, ar_hs;
  logic              unused_c;

  // Offset decode is modulo 2^32, so addresses below BASE_ADDR wrap out of range
  assign aw_off      = aw_addr - BASE_ADDR;
  assign ar_off      = ar_addr - BASE_ADDR;
  assign aw_in_range = SPAN_W'(aw_off) < SPAN;
  assign ar_in_range = SPAN_W'(ar_off) < SPAN;
  assign aw_idx      = aw_off[IDX_W+1:2];
  assign ar_idx      = ar_off[IDX_W+1:2];

  assign aw_hs = bus.awvalid && awready_q;
  assign w_hs  = bus.wvalid && wready_q;
  assign ar_hs = bus.arvalid && arready_q;

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

  assign unused_c = ^{bus.awprot[1:0], bus.arprot};

  // Write channel next-state
  always_comb begin
    w_state_d  = w_state;
    aw_held_d  = aw_held;
    w_held_d   = w_held;
    aw_addr_d  = aw_addr;
    aw_instr_d = aw_instr;
    w_data_d   = w_data;
    w_strb_d   = w_strb;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    ram_we     = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d  = 1'b1;
          aw_addr_d  = bus.awaddress;
          aw_instr_d = bus.awprot[2];
          awready_d  = 1'b0;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = bus.wdata;
          w_strb_d = bus.wstrb;
          wready_d = 1'b0;
        end
        if (aw_held_d && w_held_d) w_state_d = W_COMMIT;
      end
      W_COMMIT: begin
        bvalid_d  = 1'b1;
        w_state_d = W_RESP;
        if (!aw_in_range) begin
          bresp_d = RESP_DECERR;
        end else if (aw_instr) begin
          bresp_d = RESP_SLVERR;
        end else begin
          bresp_d = RESP_OKAY;
          ram_we  = 1'b1;
        end
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel next-state
  always_comb begin
    r_state_d = r_state;
    ar_addr_d = ar_addr;
    cnt_d     = cnt;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state)
      R_IDLE: begin
        if (ar_hs) begin
          ar_addr_d = bus.araddress;
          cnt_d     = CNT_W'(READ_WAIT);
          arready_d = 1'b0;
          r_state_d = (READ_WAIT == 0) ? R_FETCH : R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt == CNT_W'(1)) r_state_d = R_FETCH;
        else                  cnt_d     = cnt - CNT_W'(1);
      end
      R_FETCH: begin
        rvalid_d  = 1'b1;
        r_state_d = R_RESP;
        if (ar_in_range) begin
          rdata_d = mem[ar_idx];
          rresp_d = RESP_OKAY;
        end else begin
          rdata_d = '0;
          rresp_d = RESP_DECERR;
        end
      end
      R_RESP: begin
        if (bus.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // State and output registers for both channels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr   <= '0;
      aw_instr  <= 1'b0;
      w_data    <= '0;
      w_strb    <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state   <= R_IDLE;
      ar_addr   <= '0;
      cnt       <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state   <= w_state_d;
      aw_held   <= aw_held_d;
      w_held    <= w_held_d;
      aw_addr   <= aw_addr_d;
      aw_instr  <= aw_instr_d;
      w_data    <= w_data_d;
      w_strb    <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state   <= r_state_d;
      ar_addr   <= ar_addr_d;
      cnt       <= cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // RAM array is not reset; a same-edge read sample sees the old word
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_ram.sv
// Bench for axi_lite_ram: two instances (READ_WAIT 0 and 3) sharing one write stream,
// checked against an array model of the memory map.
module tb_axi_lite_ram;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WAIT1 = 3;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared write stimulus, per-instance read stimulus
  logic        awvalid, wvalid, bready;
  logic [31:0] awaddress, wdata;
  logic [2:0]  awprot;
  logic [3:0]  wstrb;
  logic        arv [2];
  logic [31:0] ara [2];
  logic [2:0]  arp [2];
  logic        rrdy [2];

  logic        awready_o [2], wready_o [2], bvalid_o [2], arready_o [2], rvalid_o [2];
  logic [1:0]  bresp_o [2], rresp_o [2];
  logic [31:0] rdata_o [2];

  logic [31:0] mem_m [DEPTH];

  axi_lite_ram_if bus0 ();
  axi_lite_ram_if busw ();

  assign bus0.awvalid = awvalid;   assign busw.awvalid = awvalid;
  assign bus0.awaddress = awaddress; assign busw.awaddress = awaddress;
  assign bus0.awprot = awprot;     assign busw.awprot = awprot;
  assign bus0.wvalid = wvalid;     assign busw.wvalid = wvalid;
  assign bus0.wdata = wdata;       assign busw.wdata = wdata;
  assign bus0.wstrb = wstrb;       assign busw.wstrb = wstrb;
  assign bus0.bready = bready;     assign busw.bready = bready;
  assign bus0.arvalid = arv[0];    assign busw.arvalid = arv[1];
  assign bus0.araddress = ara[0];  assign busw.araddress = ara[1];
  assign bus0.arprot = arp[0];     assign busw.arprot = arp[1];
  assign bus0.rready = rrdy[0];    assign busw.rready = rrdy[1];

  assign awready_o[0] = bus0.awready; assign awready_o[1] = busw.awready;
  assign wready_o[0]  = bus0.wready;  assign wready_o[1]  = busw.wready;
  assign bvalid_o[0]  = bus0.bvalid;  assign bvalid_o[1]  = busw.bvalid;
  assign bresp_o[0]   = bus0.bresp;   assign bresp_o[1]   = busw.bresp;
  assign arready_o[0] = bus0.arready; assign arready_o[1] = busw.arready;
  assign rvalid_o[0]  = bus0.rvalid;  assign rvalid_o[1]  = busw.rvalid;
  assign rdata_o[0]   = bus0.rdata;   assign rdata_o[1]   = busw.rdata;
  assign rresp_o[0]   = bus0.rresp;   assign rresp_o[1]   = busw.rresp;

  axi_lite_ram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .READ_WAIT(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  axi_lite_ram #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .READ_WAIT(WAIT1))
    dutw (.clk(clk), .reset(reset), .bus(busw));

  // ---------------- reference model ----------------
  function automatic logic [1:0] exp_wresp(input logic [31:0] a, input logic [2:0] p);
    logic [31:0] off;
    off = a - BASE;
    if (longint'(off) >= 4 * longint'(DEPTH)) return 2'b11;
    if (p[2]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, input logic [2:0] p);
    logic [31:0] off;
    off = a - BASE;
    if (exp_wresp(a, p) == 2'b00)
      for (int b = 0; b < 4; b++)
        if (s[b]) mem_m[int'(off >> 2)][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (longint'(off) >= 4 * longint'(DEPTH)) return 32'h0;
    return mem_m[int'(off >> 2)];
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (longint'(off) >= 4 * longint'(DEPTH)) ? 2'b11 : 2'b00;
  endfunction

  // ---------------- bus drivers (no checking) ----------------
  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W. bad counts protocol slips.
  task automatic drv_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot,
                           input int lead, input int bdly,
                           output logic [1:0] resp, output int lat, output int bad,
                           output int hs_cyc);
    int t, aw_start, w_start;
    bit aw_done, w_done, aw_hs, w_hs;
    aw_start = (lead < 0) ? 0 : lead;
    w_start  = (lead < 0) ? -lead : 0;
    bad = 0; lat = -1; resp = 2'bxx; hs_cyc = -1; t = 0;
    aw_done = 0; w_done = 0;
    awaddress = addr; awprot = prot; wdata = data; wstrb = strb;
    while (!(aw_done && w_done) && t < 40) begin
      awvalid = !aw_done && (t >= aw_start);
      wvalid  = !w_done && (t >= w_start);
      aw_hs = awvalid && (awready_o[0] === 1'b1);
      w_hs  = wvalid && (wready_o[0] === 1'b1);
      @(posedge clk); #1; t++;
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (aw_hs && !w_done && awready_o[0] !== 1'b0) bad++;
      if (w_hs && !aw_done && wready_o[0] !== 1'b0) bad++;
      if (!(aw_done && w_done) && bvalid_o[0] !== 1'b0) bad++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) return;
    hs_cyc = cyc;
    lat = 0;
    while (bvalid_o[0] !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    if (bvalid_o[0] !== 1'b1) begin lat = -1; return; end
    resp = bresp_o[0];
    if (awready_o[0] !== 1'b0 || wready_o[0] !== 1'b0) bad++;
    repeat (bdly) begin
      @(posedge clk); #1;
      if (bvalid_o[0] !== 1'b1 || bresp_o[0] !== resp) bad++;
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    if (bvalid_o[0] !== 1'b0 || awready_o[0] !== 1'b1 || wready_o[0] !== 1'b1) bad++;
  endtask

  task automatic drv_read(input int k, input logic [31:0] addr, input logic [2:0] prot,
                          input int rdly, output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output int bad);
    int t;
    bit hs;
    bad = 0; lat = -1; data = 32'hx; resp = 2'bxx; t = 0; hs = 0;
    ara[k] = addr; arp[k] = prot; arv[k] = 1'b1;
    while (!hs && t < 40) begin
      hs = (arready_o[k] === 1'b1);
      @(posedge clk); #1; t++;
    end
    arv[k] = 1'b0;
    if (!hs) return;
    lat = 0;
    while (rvalid_o[k] !== 1'b1 && lat < 40) begin
      if (arready_o[k] !== 1'b0) bad++;
      @(posedge clk); #1; lat++;
    end
    if (rvalid_o[k] !== 1'b1) begin lat = -1; return; end
    data = rdata_o[k]; resp = rresp_o[k];
    if (arready_o[k] !== 1'b0) bad++;
    repeat (rdly) begin
      @(posedge clk); #1;
      if (rvalid_o[k] !== 1'b1 || rdata_o[k] !== data || rresp_o[k] !== resp ||
          arready_o[k] !== 1'b0) bad++;
    end
    rrdy[k] = 1'b1;
    @(posedge clk); #1;
    rrdy[k] = 1'b0;
    if (rvalid_o[k] !== 1'b0 || arready_o[k] !== 1'b1) bad++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({awready_o[k], wready_o[k], arready_o[k]} !== 3'b111) begin
        errors++; $display("FAIL reset_ready[%0d]: got %b want 111", k,
                           {awready_o[k], wready_o[k], arready_o[k]});
      end
      checks++;
      if ({bvalid_o[k], rvalid_o[k]} !== 2'b00) begin
        errors++; $display("FAIL reset_valid[%0d]: got %b want 00", k,
                           {bvalid_o[k], rvalid_o[k]});
      end
      checks++;
      if ({bresp_o[k], rresp_o[k], rdata_o[k]} !== 36'h0) begin
        errors++; $display("FAIL reset_payload[%0d]: got %h want 0", k,
                           {bresp_o[k], rresp_o[k], rdata_o[k]});
      end
    end
  endtask

  task automatic test_fill();
    logic [1:0] r; int lat, bad, hc; logic [31:0] d;
    for (int w = 0; w < 32; w++) begin
      d = $urandom;
      drv_write(BASE + 32'(w * 4), d, 4'hF, 3'b000, 0, 0, r, lat, bad, hc);
      model_write(BASE + 32'(w * 4), d, 4'hF, 3'b000);
      checks++;
      if (r !== 2'b00 || lat !== 1 || bad !== 0) begin
        errors++; $display("FAIL fill_w%0d: resp=%b lat=%0d bad=%0d want 00/1/0", w, r, lat, bad);
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; int lat, bad, hc; logic [31:0] d;
    drv_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, r, lat, bad, hc);
    model_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b000);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_bresp: got %b want 00", r); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL basic_blat: got %0d want 1", lat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL basic_wproto: got %0d want 0", bad); end
    drv_read(0, 32'h10, 3'b000, 0, d, r, lat, bad);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rdata: got %h want deadbeef", d); end
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL basic_rresp: got %b want 00", r); end
    checks++; if (lat !== 1 || bad !== 0) begin
      errors++; $display("FAIL basic_rproto: lat=%0d bad=%0d want 1/0", lat, bad);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] r; int lat, bad, hc; logic [31:0] d;
    drv_write(32'h20, 32'h11223344, 4'hF, 3'b000, 0, 0, r, lat, bad, hc);
    model_write(32'h20, 32'h11223344, 4'hF, 3'b000);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL wfirst_pre: got %b want 00", r); end
    drv_write(32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, 3, 2, r, lat, bad, hc);
    model_write(32'h20, 32'hAABBCCDD, 4'b0101, 3'b000);
    checks++; if (lat !== 1) begin errors++; $display("FAIL wfirst_blat: got %0d want 1", lat); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL wfirst_proto: got %0d want 0", bad); end
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL wfirst_bresp: got %b want 00", r); end
    drv_read(0, 32'h20, 3'b000, 1, d, r, lat, bad);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL wfirst_rdata: got %h want 11bb33dd", d); end
  endtask

  task automatic test_decerr();
    logic [1:0] r; int lat, bad, hc; logic [31:0] d, w0;
    w0 = mem_m[0];
    drv_write(BASE + 32'(4 * DEPTH), 32'hCAFEF00D, 4'hF, 3'b000, -1, 1, r, lat, bad, hc);
    checks++; if (r !== 2'b11 || lat !== 1 || bad !== 0) begin
      errors++; $display("FAIL decerr_w: resp=%b lat=%0d bad=%0d want 11/1/0", r, lat, bad);
    end
    drv_read(0, BASE + 32'(4 * DEPTH), 3'b000, 0, d, r, lat, bad);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL decerr_rdata: got %h want 0", d); end
    checks++; if (r !== 2'b11) begin errors++; $display("FAIL decerr_rresp: got %b want 11", r); end
    drv_read(0, BASE, 3'b000, 0, d, r, lat, bad);
    checks++; if (d !== w0) begin errors++; $display("FAIL decerr_alias: got %h want %h", d, w0); end
  endtask

  task automatic test_slverr();
    logic [1:0] r; int lat, bad, hc; logic [31:0] d, old;
    old = mem_m[2];
    drv_write(32'h8, 32'h55, 4'hF, 3'b101, 0, 0, r, lat, bad, hc);
    model_write(32'h8, 32'h55, 4'hF, 3'b101);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL slverr_bresp: got %b want 10", r); end
    drv_read(0, 32'h8, 3'b101, 0, d, r, lat, bad);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL slverr_rresp: got %b want 00", r); end
    checks++; if (d !== old) begin errors++; $display("FAIL slverr_rdata: got %h want %h", d, old); end
  endtask

  task automatic test_read_wait();
    logic [1:0] r; int lat, bad; logic [31:0] d;
    drv_read(1, 32'h10, 3'b000, 5, d, r, lat, bad);
    checks++; if (lat !== WAIT1 + 1) begin errors++; $display("FAIL rwait_lat: got %0d want %0d", lat, WAIT1 + 1); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rwait_stable: got %0d want 0", bad); end
    checks++; if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      errors++; $display("FAIL rwait_data: got %h/%b want deadbeef/00", d, r);
    end
  endtask

  task automatic test_read_first();
    logic [1:0] wr, rr; int wl, wb, hc, rl, rb; logic [31:0] d, old, nw;
    old = mem_m[16];
    nw  = ~old;
    fork
      drv_write(32'h40, nw, 4'hF, 3'b000, 0, 0, wr, wl, wb, hc);
      drv_read(0, 32'h40, 3'b000, 0, d, rr, rl, rb);
    join
    model_write(32'h40, nw, 4'hF, 3'b000);
    checks++; if (d !== old) begin errors++; $display("FAIL readfirst_old: got %h want %h", d, old); end
    drv_read(0, 32'h40, 3'b000, 0, d, rr, rl, rb);
    checks++; if (d !== nw) begin errors++; $display("FAIL readfirst_new: got %h want %h", d, nw); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] r; int lat, bad, hc, prev; logic [31:0] d [4];
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom;
      drv_write(32'h60 + 32'(i * 4), d[i], 4'hF, 3'b000, 0, 0, r, lat, bad, hc);
      model_write(32'h60 + 32'(i * 4), d[i], 4'hF, 3'b000);
      if (i > 0) begin
        checks++;
        if (hc - prev !== 3) begin errors++; $display("FAIL b2b_wperiod%0d: got %0d want 3", i, hc - prev); end
      end
      prev = hc;
    end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] q;
      drv_read(i % 2, 32'h60 + 32'(i * 4), 3'b000, 0, q, r, lat, bad);
      checks++;
      if (q !== d[i] || bad !== 0) begin
        errors++; $display("FAIL b2b_read%0d: got %h bad=%0d want %h", i, q, bad, d[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] r, er; int lat, bad, hc, k; logic [31:0] a, d, s, ed;
    logic [2:0] p;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
          1: a = 32'hFFFF_FFFC;
          default: a = 32'h8000_0010;
        endcase
      end else begin
        a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
      end
      p = 3'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; s = 32'($urandom_range(0, 15));
        er = exp_wresp(a, p);
        drv_write(a, d, s[3:0], p, $urandom_range(0, 4) - 2, $urandom_range(0, 3), r, lat, bad, hc);
        model_write(a, d, s[3:0], p);
        checks++;
        if (r !== er || lat !== 1 || bad !== 0) begin
          errors++; $display("FAIL rand_w%0d a=%h: resp=%b lat=%0d bad=%0d want %b/1/0", i, a, r, lat, bad, er);
        end
      end else begin
        k = $urandom_range(0, 1);
        ed = exp_rdata(a); er = exp_rresp(a);
        drv_read(k, a, p, $urandom_range(0, 3), d, r, lat, bad);
        checks++;
        if (d !== ed || r !== er || lat !== ((k == 1) ? WAIT1 + 1 : 1) || bad !== 0) begin
          errors++; $display("FAIL rand_r%0d k=%0d a=%h: data=%h resp=%b lat=%0d bad=%0d want %h/%b",
                             i, k, a, d, r, lat, bad, ed, er);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r; int lat, bad, bseen; logic [31:0] d, old;
    old = mem_m[12];
    awaddress = 32'h30; awprot = 3'b000; wdata = ~old; wstrb = 4'hF; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    checks++; if (awready_o[0] !== 1'b0) begin errors++; $display("FAIL rstmid_awheld: got %b want 0", awready_o[0]); end
    #2 reset = 1'b1;
    #2;
    checks++;
    if ({awready_o[0], wready_o[0], arready_o[0], bvalid_o[0]} !== 4'b1110) begin
      errors++; $display("FAIL rstmid_async: got %b want 1110",
                         {awready_o[0], wready_o[0], arready_o[0], bvalid_o[0]});
    end
    @(posedge clk); #1 reset = 1'b0;
    bseen = 0;
    repeat (5) begin @(posedge clk); #1; if (bvalid_o[0] !== 1'b0 || bvalid_o[1] !== 1'b0) bseen++; end
    checks++; if (bseen !== 0) begin errors++; $display("FAIL rstmid_bvalid: got %0d want 0", bseen); end
    checks++;
    if ({awready_o[0], wready_o[0], arready_o[0], awready_o[1], wready_o[1], arready_o[1]} !== 6'h3F) begin
      errors++; $display("FAIL rstmid_ready: got %b want 111111",
                         {awready_o[0], wready_o[0], arready_o[0], awready_o[1], wready_o[1], arready_o[1]});
    end
    for (int k = 0; k < 2; k++) begin
      drv_read(k, 32'h30, 3'b000, 0, d, r, lat, bad);
      checks++; if (d !== old || r !== 2'b00) begin
        errors++; $display("FAIL rstmid_data[%0d]: got %h/%b want %h/00", k, d, r, old);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    awaddress = '0; wdata = '0; awprot = '0; wstrb = '0;
    for (int k = 0; k < 2; k++) begin arv[k] = 1'b0; ara[k] = '0; arp[k] = '0; rrdy[k] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_basic();
    test_w_first();
    test_decerr();
    test_slverr();
    test_read_wait();
    test_read_first();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
